seq_trunc_mult: RTL and testbench
=================================

Name: seq_trunc_mult

Overview:
- Parametrised, iterative successor to the flat array truncated multipliers (arrtm family).
- Computes the K-truncated product of two N-bit operands. Only partial products a[i]&b[j] with i>=K and j>=K contribute; the low 2K result bits are forced to 0.
- Sequential shift-add over M=N-K rows, one partial-product row per clock. Adds a per-transaction signed/unsigned mode.
- Valid/ready handshakes on input and output. Sits on a streaming datapath where area matters more than throughput.

Parameters:
- N, 8, operand width; N >= 2.
- K, 4, truncation point; 0 <= K < N. K=0 gives an exact multiplier. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- is_signed  input  1  1 = treat a and b as two's complement; sampled with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  2N  truncated product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Function, unsigned: out = ((a>>K)*(b>>K)) << 2K, as a 2N-bit value.
- Function, signed: out = (sext(a>>>K)*sext(b>>>K)) << 2K, as 2N-bit two's complement.
- Width: a_hi = a[N-1:K] and b_hi = b[N-1:K], each M bits. The accumulator is 2M bits and out = {acc, 2K'b0}.
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, acc=0, row counter=0.
- IDLE state:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_hi, b_hi and is_signed, clear acc, clear counter, go to CALC.
- CALC state, row j = 0..M-1:
  - acc += (b_hi[j] ? ext(a_hi) : 0) << j. ext = sign-extend if signed, else zero-extend.
  - In signed mode, row M-1 is subtracted instead of added.
  - After row M-1, go to DONE.
  - CALC lasts exactly M cycles.
- DONE state:
  - out_valid=1 and out holds the result stable while out_ready=0.
  - On out_ready go to IDLE. out_valid drops and out keeps its last value.
- Latency: out_valid rises M+1 edges after the accepting edge. For N=8, K=4 that is 5.
- Minimum initiation interval is M+2 cycles: there is no same-cycle accept in DONE, and in_ready=0 outside IDLE.
- in_valid asserted while not in IDLE is ignored: no latch, no error. Operand changes during CALC have no effect.
- Boundaries:
  - K=N-1: M=1. The single row is subtracted in signed mode, so -1*-1=1.
  - Signed most-negative inputs, e.g. (-2^(M-1))^2, fit in 2M bits; there is no overflow.
  - Reset mid-CALC or mid-DONE discards the transaction. No out_valid follows.
  - out_ready held high while idle has no effect.

Decomposition:
- Shared package tm_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - a function for counter width clog2(max(M,2));
  - localparam checks on N and K.
- One natural sub-module, tm_row_acc: a combinational row update. Inputs are acc, a_hi, the current b bit, row index, is_signed and last-row flag; output is next acc. It is reused by future pipelined variants.

Test Plan (N=8, K=4 unless stated):
- Unsigned a=0xFF, b=0xFF -> out_valid 5 edges after accept, out=0xE100. Also a=0x0F, b=0xFF -> out=0x0000.
- Signed a=0x80, b=0x80 -> out=0x4000. Signed a=0x80, b=0x7F -> out=0xC800. Signed a=0xF0, b=0xF0 -> out=0x0100.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out and out_valid stable, in_ready=0. Drive in_valid with a new pair meanwhile -> ignored; the result is unchanged.
- Reset mid-CALC: assert rst after 2 CALC cycles -> immediately IDLE, in_ready=1, out=0. No out_valid appears; the next transaction computes correctly.
- Parameter sweep: K=0 and K=7, with 1000 random transactions each in both modes, checked against a golden model -> all match. K=7 latency is 2 edges.
- Back-to-back with out_ready tied high -> one result every M+2 cycles, in-order, no drops.

Source files
------------

// File: rtl/tm_pkg.sv
// tm_pkg: shared types and parameter helpers for the truncated multiplier family.
package tm_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} tm_state_e;
    function automatic int tm_cnt_w(input int m);
        return $clog2(m > 2 ? m : 2);
    endfunction
    function automatic bit tm_params_ok(input int n, input int k);
        return n >= 2 && k >= 0 && k < n;
    endfunction
endpackage

// File: rtl/tm_row_acc.sv
// tm_row_acc: one shift-add row of the truncated product; the sign row is subtracted.
module tm_row_acc #(
    parameter int M  = 4,
    parameter int CW = 2
) (
    input  logic [2*M-1:0] acc_i,
    input  logic [M-1:0]   a_hi_i,
    input  logic           b_bit_i,
    input  logic [CW-1:0]  row_i,
    input  logic           is_signed_i,
    input  logic           last_i,
    output logic [2*M-1:0] acc_o
);
    logic [2*M-1:0] ext;
    logic [2*M-1:0] pp;
    always_comb begin
        ext   = is_signed_i ? {{M{a_hi_i[M-1]}}, a_hi_i} : {{M{1'b0}}, a_hi_i};
        pp    = b_bit_i ? ext << row_i : '0;
        acc_o = (is_signed_i && last_i) ? acc_i - pp : acc_i + pp;
    end
endmodule

// File: rtl/seq_trunc_mult.sv
// seq_trunc_mult: iterative K-truncated N x N multiplier, one partial-product row per clock.
module seq_trunc_mult
    import tm_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out,
    output logic           busy
);
    localparam int M  = N - K;
    localparam int CW = tm_cnt_w(M);
    localparam int W  = 2 * N;
    if (!tm_params_ok(N, K)) begin : g_bad_params
        $error("seq_trunc_mult: need N >= 2 and 0 <= K < N");
    end
    // Operand bits below K never reach the product.
    if (K > 0) begin : g_drop_lo
        logic unused_lo;
        assign unused_lo = ^{a[K-1:0], b[K-1:0]};
    end
    tm_state_e      state_q, state_d;
    logic [M-1:0]   a_q, a_d, b_q, b_d;
    logic           sgn_q, sgn_d;
    logic [2*M-1:0] acc_q, acc_d, row_acc;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last;
    assign last = cnt_q == CW'(M - 1);
    tm_row_acc #(.M(M), .CW(CW)) u_row (
        .acc_i      (acc_q),
        .a_hi_i     (a_q),
        .b_bit_i    (b_q[cnt_q]),
        .row_i      (cnt_q),
        .is_signed_i(sgn_q),
        .last_i     (last),
        .acc_o      (row_acc)
    );
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a[N-1:K];
                b_d     = b[N-1:K];
                sgn_d   = is_signed;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d   = row_acc;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? DONE : CALC;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out       = W'(acc_q) << (2 * K);
endmodule

// File: tb/tb_seq_trunc_mult.sv
// tb_seq_trunc_mult: directed and golden-model checks of seq_trunc_mult at K=4, K=0 and K=7.
module tb_seq_trunc_mult;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] out;
    logic        ivx, sx;
    logic [7:0]  ax, bx;
    logic        ir0, ov0, bz0, ir7, ov7, bz7;
    logic [15:0] o0, o7;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    seq_trunc_mult #(.N(8), .K(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );
    seq_trunc_mult #(.N(8), .K(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(ivx), .in_ready(ir0), .a(ax), .b(bx),
        .is_signed(sx), .out_valid(ov0), .out_ready(1'b1), .out(o0), .busy(bz0)
    );
    seq_trunc_mult #(.N(8), .K(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(ivx), .in_ready(ir7), .a(ax), .b(bx),
        .is_signed(sx), .out_valid(ov7), .out_ready(1'b1), .out(o7), .busy(bz7)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gold(input logic [7:0] x, input logic [7:0] y, input bit s, input int k);
        longint xh, yh, p;
        xh = s ? (longint'($signed(x)) >>> k) : (longint'(x) >> k);
        yh = s ? (longint'($signed(y)) >>> k) : (longint'(y) >> k);
        p  = (xh * yh) << (2 * k);
        return p[15:0];
    endfunction

    // Latency counts the accepting edge as edge 1.
    task automatic go(input logic [7:0] x, input logic [7:0] y, input logic s,
                      output logic [15:0] r, output int lat);
        a = x;
        b = y;
        is_signed = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        r = out;
    endtask

    task automatic sweep(input logic [7:0] x, input logic [7:0] y, input logic s,
                         output logic [15:0] r0, output logic [15:0] r7, output int l0, output int l7);
        chk("sweep_idle", 32'({ir0, ir7, bz0, bz7}), 32'h0000_000c);
        ax = x;
        bx = y;
        sx = s;
        ivx = 1'b1;
        tick();
        ivx = 1'b0;
        l0 = 0;
        l7 = 0;
        r0 = 'x;
        r7 = 'x;
        for (int c = 1; c <= 11; c++) begin
            if (l7 == 0 && ov7) begin r7 = o7; l7 = c; end
            if (l0 == 0 && ov0) begin r0 = o0; l0 = c; end
            tick();
        end
    endtask

    logic [7:0]  da[5] = '{8'hFF, 8'h0F, 8'h80, 8'h80, 8'hF0};
    logic [7:0]  db[5] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hF0};
    logic        ds[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] de[5] = '{16'hE100, 16'h0000, 16'h4000, 16'hC800, 16'h0100};
    logic [7:0]  qa[4] = '{8'hFF, 8'h35, 8'h80, 8'hA0};
    logic [7:0]  qb[4] = '{8'hFF, 8'h27, 8'h80, 8'h50};
    logic [15:0] qe[4] = '{16'hE100, 16'h0600, 16'h4000, 16'h3200};

    initial begin
        logic [15:0] r, r0, r7;
        logic [7:0]  x, y;
        int          lat, l0, l7, idx, ridx, last_c;
        bit          seen, took;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        ivx = 1'b0;
        ax = '0;
        bx = '0;
        sx = 1'b0;
        tick();
        tick();
        chk("rst_ctl", 32'({in_ready, out_valid, busy}), 32'h4);
        chk("rst_out", 32'(out), 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            go(da[i], db[i], ds[i], r, lat);
            chk("dir_out", 32'(r), 32'(de[i]));
            chk("dir_lat", 32'(lat), 32'd5);
            tick();
        end

        out_ready = 1'b0;
        go(8'h35, 8'h27, 1'b0, r, lat);
        chk("bp_out", 32'(r), 32'h0600);
        a = 8'hFF;
        b = 8'hFF;
        is_signed = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_ctl", 32'({out_valid, in_ready, busy}), 32'h5);
            chk("bp_hold", 32'(out), 32'h0600);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_ctl", 32'({out_valid, in_ready, busy}), 32'h2);
        chk("bp_rel_out", 32'(out), 32'h0600);
        tick();
        chk("bp_no_latch", 32'({out_valid, busy}), 32'h0);

        a = 8'hFF;
        b = 8'hFF;
        is_signed = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({in_ready, out_valid, busy}), 32'h4);
        chk("mid_rst_out", 32'(out), 32'h0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_quiet", 32'(seen), 32'h0);
        go(8'hF0, 8'hF0, 1'b1, r, lat);
        chk("post_rst_out", 32'(r), 32'h0100);
        chk("post_rst_lat", 32'(lat), 32'd5);
        tick();

        idx = 0;
        ridx = 0;
        last_c = 0;
        a = qa[0];
        b = qb[0];
        is_signed = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 40 && ridx < 4; c++) begin
            took = in_valid && in_ready;
            tick();
            if (took) begin
                idx++;
                if (idx < 4) begin
                    a = qa[idx];
                    b = qb[idx];
                end else in_valid = 1'b0;
            end
            if (out_valid) begin
                chk("b2b_out", 32'(out), 32'(qe[ridx]));
                if (ridx > 0) chk("b2b_gap", 32'(c - last_c), 32'd6);
                last_c = c;
                ridx++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_cnt", 32'(ridx), 32'd4);

        sweep(8'h80, 8'h80, 1'b1, r0, r7, l0, l7);
        chk("k7_neg1sq", 32'(r7), 32'h4000);
        chk("k0_minsq", 32'(r0), 32'h4000);
        chk("k7_lat", 32'(l7), 32'd2);
        chk("k0_lat", 32'(l0), 32'd9);
        sweep(8'hFF, 8'h80, 1'b0, r0, r7, l0, l7);
        chk("k7_u11", 32'(r7), 32'h4000);
        chk("k0_u", 32'(r0), 32'h7F80);
        for (int i = 0; i < 2000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            sweep(x, y, 1'(i & 1), r0, r7, l0, l7);
            chk("k0_rand", 32'(r0), 32'(gold(x, y, 1'(i & 1), 0)));
            chk("k7_rand", 32'(r7), 32'(gold(x, y, 1'(i & 1), 7)));
            chk("k7_rand_lat", 32'(l7), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
